// File: rtl/comparator_pkg.sv
// comparator_pkg: FSM state encoding and {lt,eq,gt} result codes for the serial comparator
package comparator_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;
  typedef logic [2:0] res_t;
  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_LT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_GT   = 3'b001;
endpackage

// File: rtl/serial_cmp_cell.sv
// serial_cmp_cell: sticky lt/eq/gt decision flops; clear arms "equal so far", first differing enabled bit decides
module serial_cmp_cell
  import comparator_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic lt,
  output logic eq,
  output logic gt
);
  res_t res;
  always_ff @(posedge clk or posedge reset)
    if (reset) res <= RES_NONE;
    else if (clear) res <= RES_EQ;
    else if (en && res == RES_EQ && a_bit != b_bit) res <= a_bit ? RES_GT : RES_LT;
  assign {lt, eq, gt} = res;
endmodule

// File: rtl/serial_unsigned_comparator.sv
// serial_unsigned_comparator: MSB-first bit-serial unsigned compare of A vs B with done pulse
// Define EARLY_EXIT_EN to finish on the first differing bit instead of always consuming WIDTH bits.
module serial_unsigned_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CNT_W-1:0] bits_used
);
  state_t state;
  logic clear, take, last;
  assign clear = state == IDLE && start;
  assign take  = state == COMPARE && bit_valid;
`ifdef EARLY_EXIT_EN
  assign last = take && (bits_used == CNT_W'(WIDTH - 1) || (eq && a_bit != b_bit));
`else
  assign last = take && bits_used == CNT_W'(WIDTH - 1);
`endif
  serial_cmp_cell u_cell (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .en    (take),
    .a_bit (a_bit),
    .b_bit (b_bit),
    .lt    (lt),
    .eq    (eq),
    .gt    (gt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_used <= '0;
    end else begin
      state     <= clear ? COMPARE : last ? DONE : state == DONE ? IDLE : state;
      busy      <= clear || (state == COMPARE && !last);
      done      <= last;
      bits_used <= clear ? '0 : take ? bits_used + CNT_W'(1) : bits_used;
    end
endmodule

// File: tb/tb_serial_unsigned_comparator.sv
// tb_serial_unsigned_comparator: randomized scoreboard bench against an arithmetic compare model
module tb_serial_unsigned_comparator;
  localparam int W = 32;
  localparam int CW = $clog2(W + 1);
  logic clk = 0, reset = 1, start = 0, bit_valid = 0, a_bit = 0, b_bit = 0;
  logic busy, done, lt, eq, gt;
  logic [CW-1:0] bits_used;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic prev_done = 0;
  typedef struct {
    logic lt, eq, gt;
    int bits, start_cyc, lat;
  } exp_t;
  exp_t q[$];

  serial_unsigned_comparator #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt), .bits_used(bits_used)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_bits(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) if (a[i] != b[i]) return W - i;
`endif
    return W;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      check("done_one_cycle", prev_done, 0);
      check("done_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("lt", lt, e.lt);
        check("eq", eq, e.eq);
        check("gt", gt, e.gt);
        check("bits_used", bits_used, e.bits);
        check("onehot", $countones({lt, eq, gt}), 1);
        check("busy_at_done", busy, 0);
        if (e.lat >= 0) check("latency", cyc - e.start_cyc, e.lat);
      end
    end
    prev_done = done;
  end

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int mode, input bit hold);
    exp_t e;
    int nb;
    nb = exp_bits(a, b);
    e.lt = a < b; e.eq = a == b; e.gt = a > b;
    e.bits = nb; e.lat = mode == 0 ? nb : -1;
    @(negedge clk); start = 1;
    @(negedge clk); start = hold; e.start_cyc = cyc;
    q.push_back(e);
    check("busy_after_start", busy, 1);
    for (int k = 0; k < nb; k++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        bit_valid = 0; a_bit = 1'($urandom); b_bit = 1'($urandom);
        @(negedge clk);
      end
      bit_valid = 1; a_bit = a[W-1-k]; b_bit = b[W-1-k];
      @(negedge clk);
    end
    bit_valid = 0;
    if (hold) begin
      @(negedge clk);
      start = 0;
    end
    for (int t = 0; t < 8 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      check("done_timeout", 0, 1);
      q.delete();
    end
    repeat (2) @(negedge clk);
    check("held_result", {lt, eq, gt}, {e.lt, e.eq, e.gt});
    check("idle_busy", {busy, done}, 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, lt, eq, gt, bits_used}, 0);
    reset = 0;
    @(negedge clk);
    run(32'h0000_0005, 32'h0000_0003, 0, 0);
    run(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    run(32'h8000_0000, 32'h7FFF_FFFF, 0, 0);
    run(32'h1234_5678, 32'h1234_5679, 1, 0);
    run(32'h0000_0000, 32'h0000_0000, 2, 0);
    run(32'hFFFF_FFFF, 32'h0000_0000, 0, 1);
    run(32'h0F0F_0F0F, 32'h0F0F_0F1F, 1, 1);
    // abort a comparison midway with an asynchronous reset
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (10) begin
      bit_valid = 1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      @(negedge clk);
    end
    bit_valid = 0;
    #1 reset = 1;
    #1 check("reset_midrun", {busy, done, lt, eq, gt, bits_used}, 0);
    @(negedge clk); reset = 0;
    run(32'h0000_0100, 32'h0000_0101, 0, 0);
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = n % 3 == 0 ? a : n % 3 == 1 ? a ^ (W'(1) << $urandom_range(0, W - 1)) : $urandom;
      run(a, b, $urandom_range(0, 2), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
